// File: rtl/axil_ram64_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_ram64_if : AXI4-Lite bus bundle (64-bit data) for axil_ram64          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface axil_ram64_if;
  logic [31:0] i_awaddr;
  logic        i_awvalid;
  logic        o_awready;
  logic [63:0] i_wdata;
  logic [7:0]  i_wstrb;
  logic        i_wvalid;
  logic        o_wready;
  logic [1:0]  o_bresp;
  logic        o_bvalid;
  logic        i_bready;
  logic [31:0] i_araddr;
  logic        i_arvalid;
  logic        o_arready;
  logic [63:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rvalid;
  logic        i_rready;

  modport slave (
    input  i_awaddr, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
           i_araddr, i_arvalid, i_rready,
    output o_awready, o_wready, o_bresp, o_bvalid, o_arready,
           o_rdata, o_rresp, o_rvalid
  );

  modport master (
    output i_awaddr, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
           i_araddr, i_arvalid, i_rready,
    input  o_awready, o_wready, o_bresp, o_bvalid, o_arready,
           o_rdata, o_rresp, o_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axil_ram64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_ram64 : AXI4-Lite slave RAM, DEPTH x 64-bit words, byte strobes       |
// | Optional macro AXIL_RAM_BOUNDS_EN: SLVERR on addresses beyond DEPTH       |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module axil_ram64 #(
  parameter int DEPTH = 1024
) (
  input  wire logic   i_clk,
  input  wire logic   i_rst_n,
  axil_ram64_if.slave bus
);
  localparam int c_idx_w = $clog2(DEPTH);

  logic [63:0] r_mem [DEPTH];

  logic               r_aw_held;
  logic               r_w_held;
  logic [31:0]        r_awaddr;
  logic [63:0]        r_wdata;
  logic [7:0]         r_wstrb;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_rvalid;
  logic [63:0]        r_rdata;
  logic [1:0]         r_rresp;

  logic               w_awready;
  logic               w_wready;
  logic               w_arready;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_commit;
  logic               w_wr_oob;
  logic               w_rd_oob;
  logic [c_idx_w-1:0] w_wr_idx;
  logic [c_idx_w-1:0] w_rd_idx;
  logic               w_unused;

  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;
  assign w_aw_hs   = bus.i_awvalid && w_awready;
  assign w_w_hs    = bus.i_wvalid && w_wready;
  assign w_ar_hs   = bus.i_arvalid && w_arready;
  assign w_commit  = r_aw_held && r_w_held;
  assign w_wr_idx  = r_awaddr[3 +: c_idx_w];
  assign w_rd_idx  = bus.i_araddr[3 +: c_idx_w];

`ifdef AXIL_RAM_BOUNDS_EN
  localparam logic [28:0] c_depth = 29'(DEPTH);
  assign w_wr_oob = (r_awaddr[31:3] >= c_depth);
  assign w_rd_oob = (bus.i_araddr[31:3] >= c_depth);
`else
  assign w_wr_oob = 1'b0;
  assign w_rd_oob = 1'b0;
`endif

  // Byte offset and (in the wrapping build) upper address bits carry no meaning.
  assign w_unused = &{1'b0, r_awaddr, bus.i_araddr};

  assign bus.o_awready = w_awready;
  assign bus.o_wready  = w_wready;
  assign bus.o_bvalid  = r_bvalid;
  assign bus.o_bresp   = r_bresp;
  assign bus.o_arready = w_arready;
  assign bus.o_rvalid  = r_rvalid;
  assign bus.o_rdata   = r_rdata;
  assign bus.o_rresp   = r_rresp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= bus.i_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= bus.i_wdata;
        r_wstrb  <= bus.i_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_oob ? 2'b10 : 2'b00;
      end else if (r_bvalid && bus.i_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Storage survives reset; only bytes with their strobe set are touched.
  always_ff @(posedge i_clk) begin
    if (w_commit && !w_wr_oob) begin
      for (int b = 0; b < 8; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read samples the array before a same-edge commit lands, giving old data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_oob ? 64'd0 : r_mem[w_rd_idx];
        r_rresp  <= w_rd_oob ? 2'b10 : 2'b00;
      end else if (r_rvalid && bus.i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axil_ram64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axil_ram64 : directed scoreboard bench for axil_ram64                   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_axil_ram64;
  logic i_clk = 1'b0;
  logic i_rst_n;

  axil_ram64_if bus();

  axil_ram64 #(.DEPTH(1024)) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] bq[$];
  r_exp_t     rq[$];
  r_exp_t     mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired, got none want event", name);
  endtask

  // Scoreboard monitor: pops on every B/R handshake.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      if (bus.o_bvalid && bus.i_bready) begin
        if (bq.size() == 0) fail_to("unexpected_b");
        else chk("bresp", 64'(bus.o_bresp), 64'(bq.pop_front()));
      end
      if (bus.o_rvalid && bus.i_rready) begin
        if (rq.size() == 0) fail_to("unexpected_r");
        else begin
          mon_e = rq.pop_front();
          chk("rdata", bus.o_rdata, mon_e.data);
          chk("rresp", 64'(bus.o_rresp), 64'(mon_e.resp));
        end
      end
    end
  end

  task automatic do_aw(input logic [31:0] a);
    bus.i_awaddr  = a;
    bus.i_awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      if (bus.o_awready) begin
        @(posedge i_clk); #1;
        bus.i_awvalid = 1'b0;
        return;
      end
    end
    bus.i_awvalid = 1'b0;
    fail_to("aw_handshake");
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s);
    bus.i_wdata  = d;
    bus.i_wstrb  = s;
    bus.i_wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      if (bus.o_wready) begin
        @(posedge i_clk); #1;
        bus.i_wvalid = 1'b0;
        return;
      end
    end
    bus.i_wvalid = 1'b0;
    fail_to("w_handshake");
  endtask

  task automatic do_ar(input logic [31:0] a);
    bus.i_araddr  = a;
    bus.i_arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      if (bus.o_arready) begin
        @(posedge i_clk); #1;
        bus.i_arvalid = 1'b0;
        return;
      end
    end
    bus.i_arvalid = 1'b0;
    fail_to("ar_handshake");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [1:0] resp);
    bq.push_back(resp);
    fork
      do_aw(a);
      do_w(d, s);
    join
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] d, input logic [1:0] resp);
    rq.push_back('{d, resp});
    do_ar(a);
    chk1("r_latency", bus.o_rvalid, 1'b1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (bq.size() == 0 && rq.size() == 0 && !bus.o_bvalid && !bus.o_rvalid) return;
      @(posedge i_clk); #1;
    end
    fail_to("idle");
  endtask

  initial begin
    bool_wait : begin end
  end

  initial begin
    logic seen;
    bus.i_awaddr  = '0;
    bus.i_awvalid = 1'b0;
    bus.i_wdata   = '0;
    bus.i_wstrb   = '0;
    bus.i_wvalid  = 1'b0;
    bus.i_bready  = 1'b1;
    bus.i_araddr  = '0;
    bus.i_arvalid = 1'b0;
    bus.i_rready  = 1'b1;
    i_rst_n       = 1'b0;

    repeat (3) @(posedge i_clk); #1;
    chk1("rst_bvalid", bus.o_bvalid, 1'b0);
    chk1("rst_rvalid", bus.o_rvalid, 1'b0);
    chk("rst_rdata", bus.o_rdata, 64'd0);
    chk("rst_bresp", 64'(bus.o_bresp), 64'd0);
    chk("rst_rresp", 64'(bus.o_rresp), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk1("post_rst_awready", bus.o_awready, 1'b1);
    chk1("post_rst_wready", bus.o_wready, 1'b1);
    chk1("post_rst_arready", bus.o_arready, 1'b1);

    // AW and W together, then read back
    do_write(32'h10, 64'h1122334455667788, 8'hFF, 2'b00);
    @(posedge i_clk); #1;
    chk1("b_latency", bus.o_bvalid, 1'b1);
    chk1("b_pending_awready", bus.o_awready, 1'b0);
    wait_idle();
    do_read(32'h10, 64'h1122334455667788, 2'b00);
    wait_idle();

    // W leads AW by three cycles, low-half strobe
    bq.push_back(2'b00);
    do_w(64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    repeat (3) @(posedge i_clk); #1;
    chk1("w_held_wready", bus.o_wready, 1'b0);
    do_aw(32'h10);
    wait_idle();
    do_read(32'h10, 64'h11223344_BBBBBBBB, 2'b00);
    wait_idle();

    // B back-pressure
    bus.i_bready = 1'b0;
    do_write(32'h18, 64'h0123456789ABCDEF, 8'hFF, 2'b00);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (bus.o_bvalid) seen = 1'b1;
      else begin @(posedge i_clk); #1; end
    end
    if (!seen) fail_to("bvalid_wait");
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk1("stall_bvalid", bus.o_bvalid, 1'b1);
      chk1("stall_awready", bus.o_awready, 1'b0);
      chk1("stall_wready", bus.o_wready, 1'b0);
    end
    @(posedge i_clk); #1;
    bus.i_bready = 1'b1;
    @(posedge i_clk); #1;
    chk1("release_bvalid", bus.o_bvalid, 1'b0);
    chk1("release_awready", bus.o_awready, 1'b1);
    chk1("release_wready", bus.o_wready, 1'b1);
    wait_idle();

    // Zero-strobe write leaves the word alone
    do_write(32'h18, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 2'b00);
    wait_idle();
    do_read(32'h18, 64'h0123456789ABCDEF, 2'b00);
    wait_idle();

    // Read and commit to the same word on the same edge
    bq.push_back(2'b00);
    rq.push_back('{64'h11223344_BBBBBBBB, 2'b00});
    fork
      do_aw(32'h10);
      do_w(64'hCAFEF00D_12345678, 8'hFF);
    join
    bus.i_araddr  = 32'h10;
    bus.i_arvalid = 1'b1;
    @(posedge i_clk); #1;
    bus.i_arvalid = 1'b0;
    chk1("collide_rvalid", bus.o_rvalid, 1'b1);
    chk1("collide_bvalid", bus.o_bvalid, 1'b1);
    wait_idle();
    do_read(32'h10, 64'hCAFEF00D_12345678, 2'b00);
    wait_idle();

    // Address beyond DEPTH
    do_write(32'h0, 64'h0F0E0D0C_0B0A0908, 8'hFF, 2'b00);
    wait_idle();
`ifdef AXIL_RAM_BOUNDS_EN
    do_write(32'h2000, 64'h55555555_55555555, 8'hFF, 2'b10);
    wait_idle();
    do_read(32'h0, 64'h0F0E0D0C_0B0A0908, 2'b00);
    wait_idle();
    do_read(32'h2000, 64'd0, 2'b10);
    wait_idle();
`else
    do_write(32'h2000, 64'h55555555_55555555, 8'hFF, 2'b00);
    wait_idle();
    do_read(32'h0, 64'h55555555_55555555, 2'b00);
    wait_idle();
    do_read(32'h2000, 64'h55555555_55555555, 2'b00);
    wait_idle();
`endif

    // Asynchronous reset with AW held and R pending
    bus.i_rready = 1'b0;
    do_ar(32'h10);
    do_aw(32'h20);
    @(negedge i_clk);
    chk1("pre_rst_rvalid", bus.o_rvalid, 1'b1);
    chk1("pre_rst_awready", bus.o_awready, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk1("async_rst_rvalid", bus.o_rvalid, 1'b0);
    chk1("async_rst_awready", bus.o_awready, 1'b1);
    chk("async_rst_rdata", bus.o_rdata, 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n      = 1'b1;
    bus.i_rready = 1'b1;
    @(posedge i_clk); #1;
    do_read(32'h10, 64'hCAFEF00D_12345678, 2'b00);
    wait_idle();
    do_w(64'h99999999_99999999, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      chk1("w_only_no_b", bus.o_bvalid, 1'b0);
    end
    chk1("w_only_wready", bus.o_wready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/axil_ram64.md
AXIL_RAM64 -- requirements
Module: axil_ram64

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 64-bit words (power of two, >=2).
REQ-002 SHALL have one clock, i_clk; reset i_rst_n is asynchronous, active-low.
REQ-003 SHALL have ports:
- i_clk  input  1  clock
- i_rst_n  input  1  async active-low reset
- i_awaddr  input  32  write byte address
- i_awvalid  input  1  AW valid
- o_awready  output  1  AW ready
- i_wdata  input  64  write data
- i_wstrb  input  8  byte strobes (bit n = wdata[8n+7:8n])
- i_wvalid  input  1  W valid
- o_wready  output  1  W ready
- o_bresp  output  2  write response
- o_bvalid  output  1  B valid
- i_bready  input  1  B ready
- i_araddr  input  32  read byte address
- i_arvalid  input  1  AR valid
- o_arready  output  1  AR ready
- o_rdata  output  64  read data
- o_rresp  output  2  read response
- o_rvalid  output  1  R valid
- i_rready  input  1  R ready

Function
REQ-004 SHALL decode word index = addr[3 +: log2(DEPTH)]; addr[2:0] ignored.
REQ-005 SHALL hold at most one AW and one W in separate holding registers; o_awready = !aw_held & !o_bvalid; o_wready = !w_held & !o_bvalid.
REQ-006 SHALL accept AW and W in any order, same cycle or different cycles; a handshake sets the corresponding held flag on the next edge.
REQ-007 SHALL commit the write on the edge where aw_held & w_held, updating only bytes with strobe set, clear both held flags and set o_bvalid on that same edge.
REQ-008 SHALL hold o_bvalid and o_bresp stable until i_bready; o_bvalid clears on the edge where o_bvalid & i_bready.
REQ-009 SHALL drive o_arready = !o_rvalid; AR handshake captures the word and sets o_rvalid on the next edge (latency 1).
REQ-010 SHALL hold o_rvalid, o_rdata, o_rresp stable until i_rready; o_rvalid clears on o_rvalid & i_rready; no new AR accepted that cycle.
REQ-011 SHALL return pre-write data when an AR handshake and a write commit to the same word occur on the same edge.
REQ-012 SHALL operate read and write channels fully independently; neither stalls the other.
REQ-013 SHALL never assert valid without data, never drop a held AW/W, and have at most one outstanding B and one outstanding R.
REQ-014 SHALL ignore a write with i_wstrb == 8'h00 (no byte changes), still returning a B response.

Reset
REQ-015 SHALL on i_rst_n low immediately clear o_bvalid, o_rvalid, aw_held, w_held; o_rdata = 0, o_bresp = 0, o_rresp = 0.
REQ-016 SHALL drive o_awready, o_wready, o_arready = 1 in the first cycle after reset release.
REQ-017 SHALL discard held, uncommitted AW/W on reset; already-committed memory contents are retained, not reset.

Configuration
REQ-018 SHALL with AXIL_RAM_BOUNDS_EN defined: addr[31:3] >= DEPTH on a write gives o_bresp = 2'b10 (SLVERR) with memory unchanged; on a read gives o_rresp = 2'b10, o_rdata = 0.
REQ-019 SHALL without AXIL_RAM_BOUNDS_EN: upper address bits are ignored (index wraps modulo DEPTH) and responses are always 2'b00.

Verification
REQ-020 SHALL cover: AW 0x10 and W 0x1122334455667788, wstrb 0xFF, same cycle -> o_bvalid next edge, bresp 0; AR 0x10 -> rdata 0x1122334455667788 one cycle after.
REQ-021 SHALL cover: W first with wstrb 0x0F, data 0xAAAAAAAA_BBBBBBBB, AW to 0x10 three cycles later -> read of 0x10 gives 0x11223344_BBBBBBBB.
REQ-022 SHALL cover: i_bready held low 5 cycles -> o_bvalid stays 1, o_awready and o_wready stay 0; both release one edge after the bready handshake.
REQ-023 SHALL cover: AR to 0x10 on the same edge as a write commit to 0x10 -> rdata returns the old word.
REQ-024 SHALL cover: i_rst_n pulsed low while aw_held = 1 and o_rvalid = 1 -> both clear asynchronously; the next W alone produces no B.
REQ-025 SHALL cover: with AXIL_RAM_BOUNDS_EN and DEPTH = 1024, write to 0x2000 -> bresp 2'b10 and word 0 unchanged; without the macro, same write -> bresp 0 and word 0 updated.
